// File: rtl/spike_input_buffer.sv
// Double-buffered Wishbone spike memory: the host fills a shadow bank per core while
// the active bank drives the core; a tick or software swap copies shadow into active.
module spike_input_buffer #(
  parameter int unsigned NUM_CORES     = 2,
  parameter int unsigned NUM_AXONS     = 256,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter logic [31:0] CORE_STRIDE   = 32'h0001_0000,
  parameter bit          CLEAR_ON_SWAP = 1'b1
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_we_i,
  input  logic [3:0]                     wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [31:0]                    wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic [31:0]                    wbs_dat_o,
  input  logic [NUM_CORES-1:0]           core_en_i,
  input  logic                           tick_i,
  output logic [NUM_CORES*NUM_AXONS-1:0] spike_axon_o,
  output logic [NUM_CORES-1:0]           swap_done_o
);
  localparam int unsigned WORDS      = NUM_AXONS / 32;
  localparam int unsigned WW         = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] WIN_BYTES  = 32'(4 * WORDS);
  localparam logic [31:0] STATUS_OFF = 32'h0000_0800;

  logic [NUM_CORES-1:0][WORDS-1:0][31:0] shadow_q, shadow_d;
  logic [NUM_CORES-1:0][WORDS-1:0][31:0] active_q, active_d;
  logic [NUM_CORES-1:0][15:0]            swap_cnt_q, swap_cnt_d;
  logic [NUM_CORES-1:0]                  dirty_q, dirty_d;
  logic [NUM_CORES-1:0]                  swap_done_q, swap_done_d;
  logic                                  ack_q, ack_d;
  logic [31:0]                           dat_q, dat_d;

  logic                        req;
  logic [NUM_CORES-1:0]        hit_word, hit_status, swap_now, wr_now;
  logic [NUM_CORES-1:0][WW-1:0] word_idx;

  // Side effects happen only on the edge that raises ack.
  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;

  genvar gi, gw;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [31:0] off;
      logic        in_win;
      assign off    = wbs_adr_i - (BASE_ADDR + 32'(gi) * CORE_STRIDE);
      assign in_win = (off < CORE_STRIDE);
      assign hit_word[gi]   = in_win && (off < WIN_BYTES);
      assign hit_status[gi] = in_win && (off == STATUS_OFF);
      assign word_idx[gi]   = off[WW+1:2];
      assign wr_now[gi]     = req && wbs_we_i && hit_word[gi] && core_en_i[gi];
      assign swap_now[gi]   = core_en_i[gi] && (tick_i ||
                              (req && wbs_we_i && hit_status[gi] && wbs_sel_i[0] && wbs_dat_i[0]));

      // Word 0 sits at the MSBs of the core's slice.
      for (gw = 0; gw < WORDS; gw++) begin : g_word
        assign spike_axon_o[gi*NUM_AXONS + NUM_AXONS-1-32*gw -: 32] = active_q[gi][gw];
      end
    end
  endgenerate

  always_comb begin
    ack_d       = req;
    dat_d       = dat_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    swap_cnt_d  = swap_cnt_q;
    dirty_d     = dirty_q;
    swap_done_d = swap_now;

    if (req && !wbs_we_i) begin
      dat_d = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (hit_word[c]) begin
          dat_d = shadow_q[c][word_idx[c]];
        end else if (hit_status[c]) begin
          dat_d = {swap_cnt_q[c], 15'b0, dirty_q[c]};
        end
      end
    end

    // Swap first, then the write lands on the post-swap shadow.
    for (int c = 0; c < NUM_CORES; c++) begin
      if (swap_now[c]) begin
        active_d[c]   = shadow_q[c];
        dirty_d[c]    = 1'b0;
        swap_cnt_d[c] = swap_cnt_q[c] + 16'd1;
        if (CLEAR_ON_SWAP) begin
          shadow_d[c] = '0;
        end
      end
      if (wr_now[c]) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs_sel_i[b]) begin
            shadow_d[c][word_idx[c]][8*b +: 8] = wbs_dat_i[8*b +: 8];
          end
        end
        dirty_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shadow_q    <= '0;
      active_q    <= '0;
      swap_cnt_q  <= '0;
      dirty_q     <= '0;
      swap_done_q <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      swap_cnt_q  <= swap_cnt_d;
      dirty_q     <= dirty_d;
      swap_done_q <= swap_done_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign swap_done_o = swap_done_q;
endmodule

// File: tb/tb_spike_input_buffer.sv
// Randomized bench for spike_input_buffer: a behavioural bank model is checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_spike_input_buffer;
  localparam int NC = 2;
  localparam int NA = 256;
  localparam int W  = NA / 32;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] STRIDE = 32'h0001_0000;

  logic           clk = 1'b0, rst = 1'b0;
  logic           cyc = 1'b0, stb = 1'b0, we = 1'b0, tick = 1'b0;
  logic [3:0]     sel = 4'h0;
  logic [31:0]    adr = '0, dat = '0;
  logic [NC-1:0]  en = 2'b11;
  logic           ack;
  logic [31:0]    dat_o;
  logic [NC*NA-1:0] spike;
  logic [NC-1:0]  done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spike_input_buffer #(
    .NUM_CORES(NC), .NUM_AXONS(NA), .BASE_ADDR(BASE),
    .CORE_STRIDE(STRIDE), .CLEAR_ON_SWAP(1'b1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .core_en_i(en), .tick_i(tick), .spike_axon_o(spike), .swap_done_o(done)
  );

  task automatic chk(input string name, input logic [NC*NA-1:0] act, input logic [NC*NA-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]   m_sh[NC][W];
  logic [31:0]   m_act[NC][W];
  logic [15:0]   m_cnt[NC];
  logic          m_dirty[NC];
  logic          m_ack = 1'b0, m_rd = 1'b0;
  logic [31:0]   m_dat = '0;
  logic [NC-1:0] m_done = '0;

  function automatic int find_core(input logic [31:0] a, output logic [31:0] off);
    for (int i = 0; i < NC; i++) begin
      off = a - (BASE + 32'(i) * STRIDE);
      if (off < STRIDE) return i;
    end
    off = '0;
    return -1;
  endfunction

  function automatic logic [NC*NA-1:0] exp_spike();
    logic [NC*NA-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < W; k++)
        v[c*NA + NA-1-32*k -: 32] = m_act[c][k];
    return v;
  endfunction

  task automatic model_step();
    logic req, is_word, is_stat;
    logic [31:0] off;
    logic [NC-1:0] swp;
    int c, kw;
    req     = cyc && stb && !m_ack;
    c       = find_core(adr, off);
    kw      = int'(off >> 2);
    is_word = req && (c >= 0) && (off < 32'(4 * W));
    is_stat = req && (c >= 0) && (off == 32'h800);
    m_rd    = req && !we;
    if (req && !we) begin
      if (is_word)      m_dat = m_sh[c][kw];
      else if (is_stat) m_dat = {m_cnt[c], 15'd0, m_dirty[c]};
      else              m_dat = 32'd0;
    end
    for (int i = 0; i < NC; i++)
      swp[i] = en[i] && (tick || (is_stat && we && (c == i) && sel[0] && dat[0]));
    for (int i = 0; i < NC; i++) begin
      if (swp[i]) begin
        for (int k = 0; k < W; k++) begin
          m_act[i][k] = m_sh[i][k];
          m_sh[i][k]  = 32'd0;
        end
        m_dirty[i] = 1'b0;
        m_cnt[i]   = m_cnt[i] + 16'd1;
      end
    end
    if (is_word && we && en[c]) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) m_sh[c][kw][8*b +: 8] = dat[8*b +: 8];
      m_dirty[c] = 1'b1;
    end
    m_ack  = req;
    m_done = swp;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        for (int k = 0; k < W; k++) begin
          m_sh[c][k]  = '0;
          m_act[c][k] = '0;
        end
        m_cnt[c]   = '0;
        m_dirty[c] = 1'b0;
      end
      m_ack = 1'b0; m_rd = 1'b0; m_dat = '0; m_done = '0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cyc_ack", ack, m_ack);
    chk("cyc_done", done, m_done);
    chk("cyc_spike", spike, exp_spike());
    if (m_rd) chk("cyc_rdata", dat_o, m_dat);
  end

  // ---------------- stimulus helpers ----------------
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic tk, output logic [31:0] rd);
    @(negedge clk);
    chk("pre_ack_low", ack, 0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; tick = tk;
    @(negedge clk);
    chk("ack_high", ack, 1);
    rd  = dat_o;
    cyc = 1'b0; stb = 1'b0; tick = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    xfer(1'b1, a, d, s, 1'b0, r);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, 32'd0, 4'h0, 1'b0, r);
    chk(name, r, exp);
  endtask

  task automatic tick_pulse(input logic [NC-1:0] exp_done);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("tick_done", done, exp_done);
    @(negedge clk);
    chk("tick_done_clear", done, 0);
  endtask

  initial begin
    logic [31:0] r, a, d;
    int op, c, k;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_spike", spike, 0);
    chk("rst_done", done, 0);

    // T1: shadow write, status, tick swap
    en = 2'b11;
    wr(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    chk("t1_active_unchanged", spike[255:224], 0);
    rd_chk("t1_readback", 32'h8000_0000, 32'hDEAD_BEEF);
    rd_chk("t1_status_dirty", 32'h8000_0800, 32'h0000_0001);
    en = 2'b01;
    tick_pulse(2'b01);
    chk("t1_active", spike[255:224], 32'hDEAD_BEEF);
    rd_chk("t1_status_after", 32'h8000_0800, 32'h0001_0000);
    rd_chk("t1_shadow_cleared", 32'h8000_0000, 32'h0);

    // T2: byte-lane write
    en = 2'b11;
    wr(32'h8000_0000, 32'h1122_3344, 4'hF);
    wr(32'h8000_0000, 32'hAABB_CCDD, 4'b0010);
    rd_chk("t2_byte_lane", 32'h8000_0000, 32'h1122_CC44);

    // T3: write and tick on the same edge
    wr(32'h8001_001C, 32'hCAFE_F00D, 4'hF);
    xfer(1'b1, 32'h8001_001C, 32'h0000_0001, 4'hF, 1'b1, r);
    chk("t3_done", done, 2'b11);
    chk("t3_core1_w7_old", spike[287:256], 32'hCAFE_F00D);
    chk("t3_core0_w0", spike[255:224], 32'h1122_CC44);
    rd_chk("t3_shadow_w7", 32'h8001_001C, 32'h0000_0001);
    rd_chk("t3_status1", 32'h8001_0800, 32'h0001_0001);

    // T4: disabled core and unmapped addresses
    en = 2'b01;
    wr(32'h8001_0004, 32'h1234_5678, 4'hF);
    en = 2'b11;
    rd_chk("t4_dropped", 32'h8001_0004, 32'h0);
    rd_chk("t4_unmapped_hole", 32'h8000_0400, 32'h0);
    rd_chk("t4_unmapped_far", 32'h9000_0000, 32'h0);
    rd_chk("t4_status1_same", 32'h8001_0800, 32'h0001_0001);

    // T5: software swap on core 0 alone, then counter wrap
    wr(32'h8000_000C, 32'h0F0F_0F0F, 4'hF);
    xfer(1'b1, 32'h8000_0800, 32'h0000_0001, 4'h1, 1'b0, r);
    chk("t5_sw_done", done, 2'b01);
    chk("t5_core0_w3", spike[159:128], 32'h0F0F_0F0F);
    chk("t5_core1_kept", spike[287:256], 32'hCAFE_F00D);
    rd_chk("t5_status0", 32'h8000_0800, 32'h0003_0000);
    rd_chk("t5_status1", 32'h8001_0800, 32'h0001_0001);
    en = 2'b01;
    @(negedge clk);
    tick = 1'b1;
    repeat (65533) @(negedge clk);
    tick = 1'b0;
    en = 2'b11;
    rd_chk("t5_cnt_wrap", 32'h8000_0800, 32'h0000_0000);
    rd_chk("t5_status1_unchanged", 32'h8001_0800, 32'h0001_0001);

    // Randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) en = 2'($urandom);
      c  = $urandom_range(0, NC - 1);
      k  = $urandom_range(0, W - 1);
      d  = $urandom;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: xfer(1'b1, BASE + 32'(c) * STRIDE + 32'(4 * k), d, 4'($urandom),
                         ($urandom_range(0, 7) == 0), r);
        4, 5:       xfer(1'b0, BASE + 32'(c) * STRIDE + 32'(4 * k), d, 4'hF,
                         ($urandom_range(0, 7) == 0), r);
        6:          xfer(1'b0, BASE + 32'(c) * STRIDE + 32'h800, d, 4'hF, 1'b0, r);
        7:          xfer(1'b1, BASE + 32'(c) * STRIDE + 32'h800, d, 4'($urandom), 1'b0, r);
        8: begin
          a = ($urandom_range(0, 1) == 0) ? BASE + 32'(c) * STRIDE + 32'h400 + 32'(4 * k)
                                          : 32'h8002_0000 + 32'(4 * k);
          xfer(1'($urandom), a, d, 4'hF, 1'b0, r);
        end
        default: begin
          @(negedge clk);
          tick = 1'b1;
          @(negedge clk);
          tick = 1'b0;
        end
      endcase
    end

    // T6: asynchronous reset in the middle of an ack cycle
    en = 2'b11;
    wr(32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
    tick_pulse(2'b11);
    chk("t6_loaded", spike[255:224], 32'hFFFF_FFFF);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8000_0800;
    @(posedge clk);
    #1;
    chk("t6_ack_before_rst", ack, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_dat", dat_o, 0);
    chk("t6_rst_spike", spike, 0);
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_ack_after", ack, 0);
    end
    rd_chk("t6_status_cleared", 32'h8000_0800, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
